// File: rtl/rv32_ahb_sram_slave_pkg.sv
// rv32_ahb_sram_slave_pkg: shared AHB-Lite encodings and slave state type
package rv32_ahb_sram_slave_pkg;
  localparam int XLEN = 32;
  localparam logic [1:0] AHB_IDLE   = 2'b00;
  localparam logic [1:0] AHB_BUSY   = 2'b01;
  localparam logic [1:0] AHB_NONSEQ = 2'b10;
  localparam logic [1:0] AHB_SEQ    = 2'b11;
  localparam logic [2:0] AHB_SIZE_BYTE = 3'b000;
  localparam logic [2:0] AHB_SIZE_HALF = 3'b001;
  localparam logic [2:0] AHB_SIZE_WORD = 3'b010;
  localparam logic AHB_RESP_OKAY  = 1'b0;
  localparam logic AHB_RESP_ERROR = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_RD_COL, S_ERR1, S_ERR2} ahb_slv_state_e;
endpackage

// File: rtl/rv32_ahb_sram_slave_if.sv
// rv32_ahb_sram_slave_if: AHB-Lite slave-side bus bundle
interface rv32_ahb_sram_slave_if import rv32_ahb_sram_slave_pkg::*; ();
  logic            HSEL;
  logic [XLEN-1:0] HADDR;
  logic [1:0]      HTRANS;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [XLEN-1:0] HWDATA;
  logic            HREADY;
  logic [XLEN-1:0] HRDATA;
  logic            HREADYOUT;
  logic            HRESP;
  modport master (output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
                  input HRDATA, HREADYOUT, HRESP);
  modport slave  (input HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
                  output HRDATA, HREADYOUT, HRESP);
endinterface

// File: rtl/rv32_ahb_be_gen.sv
// rv32_ahb_be_gen: HSIZE/address alignment check and byte-lane enables
module rv32_ahb_be_gen import rv32_ahb_sram_slave_pkg::*; (
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic       legal,
  output logic [3:0] be
);
  always_comb begin
    legal = (size == AHB_SIZE_BYTE) || (size == AHB_SIZE_HALF && !addr_lo[0]) ||
            (size == AHB_SIZE_WORD && addr_lo == 2'b00);
    be = size == AHB_SIZE_BYTE ? 4'b0001 << addr_lo :
         size == AHB_SIZE_HALF ? 4'b0011 << addr_lo : 4'b1111;
  end
endmodule

// File: rtl/rv32_ahb_sram_slave.sv
// rv32_ahb_sram_slave: AHB-Lite to single-port SRAM bridge with wait states and collision stall
module rv32_ahb_sram_slave import rv32_ahb_sram_slave_pkg::*; #(
  parameter int DEPTH_WORDS = 16384,
  parameter int WAIT_STATES = 0,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  rv32_ahb_sram_slave_if.slave  ahb,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [3:0]            sram_be,
  output logic [AW-1:0]         sram_addr,
  output logic [XLEN-1:0]       sram_wdata,
  input  logic [XLEN-1:0]       sram_rdata
);
  ahb_slv_state_e state, nxt;
  logic [2:0] cnt;
  logic [AW-1:0] addr_q, addr_c;
  logic [3:0] be_q, be_new, be_c;
  logic fin, acc, legal_al, legal, take, load, cap, cs_c, we_c, ready, resp;
  logic [XLEN-1:0] rdata;
  rv32_ahb_be_gen u_be (.size(ahb.HSIZE), .addr_lo(ahb.HADDR[1:0]), .legal(legal_al), .be(be_new));
  assign fin   = cnt == 3'd0;
  assign acc   = ahb.HSEL && ahb.HREADY && (ahb.HTRANS == AHB_NONSEQ || ahb.HTRANS == AHB_SEQ);
  assign legal = legal_al && ~|ahb.HADDR[XLEN-1:AW+2];
  always_comb begin
    nxt = state;
    load = 1'b0;
    take = 1'b0;
    cap = 1'b0;
    ready = 1'b1;
    resp = AHB_RESP_OKAY;
    rdata = '0;
    cs_c = 1'b0;
    we_c = 1'b0;
    be_c = '0;
    addr_c = addr_q;
    case (state)
      S_IDLE: take = 1'b1;
      S_RD: begin
        ready = fin;
        rdata = fin ? sram_rdata : '0;
        take = fin;
        nxt = fin ? S_IDLE : S_RD;
      end
      S_WR: begin
        ready = fin;
        cs_c = fin;
        we_c = fin;
        be_c = fin ? be_q : '0;
        take = fin;
        nxt = fin ? S_IDLE : S_WR;
      end
      S_RD_COL: begin
        ready = 1'b0;
        cs_c = 1'b1;
        load = 1'b1;
        nxt = S_RD;
      end
      S_ERR1: begin
        ready = 1'b0;
        resp = AHB_RESP_ERROR;
        nxt = S_ERR2;
      end
      default: begin
        resp = AHB_RESP_ERROR;
        nxt = S_IDLE;
      end
    endcase
    // The port is busy with the write in WR's last cycle, so a read accepted then is deferred
    if (take && acc) begin
      cap = legal;
      load = legal;
      if (!legal) nxt = S_ERR1;
      else if (ahb.HWRITE) nxt = S_WR;
      else if (state == S_WR) nxt = S_RD_COL;
      else begin
        nxt = S_RD;
        cs_c = 1'b1;
        addr_c = ahb.HADDR[AW+1:2];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      addr_q <= '0;
      be_q <= '0;
    end else begin
      state <= nxt;
      cnt <= load ? 3'(WAIT_STATES) : fin ? cnt : cnt - 3'd1;
      if (cap) begin
        addr_q <= ahb.HADDR[AW+1:2];
        be_q <= be_new;
      end
    end
  end
  assign sram_cs = cs_c && !rst;
  assign sram_we = we_c && !rst;
  assign sram_be = sram_we ? be_c : '0;
  assign sram_addr = addr_c;
  assign sram_wdata = ahb.HWDATA;
  assign ahb.HRDATA = rdata;
  assign ahb.HREADYOUT = ready;
  assign ahb.HRESP = resp;
endmodule

// File: tb/tb_rv32_ahb_sram_slave.sv
// tb_rv32_ahb_sram_slave: directed checks of the AHB SRAM slave with zero and three wait states
module tb_rv32_ahb_sram_slave;
  import rv32_ahb_sram_slave_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rv32_ahb_sram_slave_if a0 ();
  rv32_ahb_sram_slave_if a1 ();
  assign a0.HREADY = a0.HREADYOUT;
  assign a1.HREADY = a1.HREADYOUT;
  logic cs0, we0, cs1, we1;
  logic [3:0] be0, be1;
  logic [13:0] addr0, addr1;
  logic [31:0] wd0, wd1, rd0, rd1;
  logic [31:0] mem0 [0:16383];
  logic [31:0] mem1 [0:16383];
  rv32_ahb_sram_slave #(.DEPTH_WORDS(16384), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .ahb(a0), .sram_cs(cs0), .sram_we(we0), .sram_be(be0),
    .sram_addr(addr0), .sram_wdata(wd0), .sram_rdata(rd0));
  rv32_ahb_sram_slave #(.DEPTH_WORDS(16384), .WAIT_STATES(3)) u1 (
    .clk(clk), .rst(rst), .ahb(a1), .sram_cs(cs1), .sram_we(we1), .sram_be(be1),
    .sram_addr(addr1), .sram_wdata(wd1), .sram_rdata(rd1));
  always @(posedge clk) begin
    if (cs0) begin
      if (we0) begin
        for (int i = 0; i < 4; i++) if (be0[i]) mem0[addr0][8*i+:8] <= wd0[8*i+:8];
      end else rd0 <= mem0[addr0];
    end
    if (cs1) begin
      if (we1) begin
        for (int j = 0; j < 4; j++) if (be1[j]) mem1[addr1][8*j+:8] <= wd1[8*j+:8];
      end else rd1 <= mem1[addr1];
    end
  end
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic adv;
    @(posedge clk);
    #1;
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  task automatic ap0(input logic [1:0] tr, input logic wr, input logic [2:0] sz, input logic [31:0] ad);
    a0.HSEL = 1'b1;
    a0.HTRANS = tr;
    a0.HWRITE = wr;
    a0.HSIZE = sz;
    a0.HADDR = ad;
  endtask
  task automatic idle0;
    ap0(AHB_IDLE, 1'b0, AHB_SIZE_WORD, 32'h0);
  endtask
  task automatic err0(input string tag, input logic [31:0] ad, input logic [2:0] sz);
    ap0(AHB_NONSEQ, 1'b0, sz, ad);
    mid;
    chk({tag, "_ap_cs"}, cs0, 1'b0);
    adv;
    idle0;
    mid;
    chk({tag, "_e1_rdy"}, a0.HREADYOUT, 1'b0);
    chk({tag, "_e1_resp"}, a0.HRESP, 1'b1);
    chk({tag, "_e1_cs"}, cs0, 1'b0);
    adv;
    mid;
    chk({tag, "_e2_rdy"}, a0.HREADYOUT, 1'b1);
    chk({tag, "_e2_resp"}, a0.HRESP, 1'b1);
    chk({tag, "_e2_cs"}, cs0, 1'b0);
    adv;
    mid;
    chk({tag, "_done_resp"}, a0.HRESP, 1'b0);
    adv;
  endtask
  initial begin
    idle0;
    a0.HWDATA = '0;
    a1.HSEL = 1'b0; a1.HTRANS = AHB_IDLE; a1.HWRITE = 1'b0;
    a1.HSIZE = AHB_SIZE_WORD; a1.HADDR = '0; a1.HWDATA = '0;
    mem0[0] = 32'h1111_1111;
    mem0[1] = 32'h2222_2222;
    mem0[2] = 32'h3333_3333;
    mem1[8] = 32'h0BAD_CAFE;
    adv;
    adv;
    rst = 1'b0;
    mid;
    chk("rst_rdy", a0.HREADYOUT, 1'b1);
    chk("rst_resp", a0.HRESP, 1'b0);
    chk("rst_rdata", a0.HRDATA, 32'h0);
    chk("rst_cs", cs0, 1'b0);
    chk("rst_be", be0, 4'h0);
    adv;
    ap0(AHB_NONSEQ, 1'b1, AHB_SIZE_WORD, 32'h10);
    mid;
    chk("wr_ap_cs", cs0, 1'b0);
    adv;
    a0.HWDATA = 32'hDEAD_BEEF;
    ap0(AHB_NONSEQ, 1'b0, AHB_SIZE_WORD, 32'h10);
    mid;
    chk("wr_cs", cs0, 1'b1);
    chk("wr_we", we0, 1'b1);
    chk("wr_be", be0, 4'hF);
    chk("wr_addr", addr0, 14'd4);
    chk("wr_wdata", wd0, 32'hDEAD_BEEF);
    chk("wr_rdy", a0.HREADYOUT, 1'b1);
    adv;
    idle0;
    mid;
    chk("col_rdy", a0.HREADYOUT, 1'b0);
    chk("col_cs", cs0, 1'b1);
    chk("col_we", we0, 1'b0);
    chk("col_rdata", a0.HRDATA, 32'h0);
    adv;
    ap0(AHB_NONSEQ, 1'b1, AHB_SIZE_BYTE, 32'h13);
    mid;
    chk("rd_data", a0.HRDATA, 32'hDEAD_BEEF);
    chk("rd_rdy", a0.HREADYOUT, 1'b1);
    adv;
    a0.HWDATA = 32'hAA00_0000;
    ap0(AHB_NONSEQ, 1'b1, AHB_SIZE_HALF, 32'h12);
    mid;
    chk("byte_be", be0, 4'b1000);
    chk("byte_addr", addr0, 14'd4);
    chk("byte_we", we0, 1'b1);
    adv;
    a0.HWDATA = 32'h1234_0000;
    ap0(AHB_NONSEQ, 1'b0, AHB_SIZE_WORD, 32'h10);
    mid;
    chk("half_be", be0, 4'b1100);
    chk("half_cs", cs0, 1'b1);
    adv;
    idle0;
    mid;
    chk("col2_rdy", a0.HREADYOUT, 1'b0);
    adv;
    mid;
    chk("merge_data", a0.HRDATA, 32'h1234_BEEF);
    adv;
    err0("w_mis", 32'h2, AHB_SIZE_WORD);
    err0("h_mis", 32'h5, AHB_SIZE_HALF);
    err0("sz3", 32'h0, 3'b011);
    err0("oor", 32'h0001_0000, AHB_SIZE_WORD);
    ap0(AHB_NONSEQ, 1'b0, AHB_SIZE_WORD, 32'h0);
    mid;
    chk("p0_cs", cs0, 1'b1);
    chk("p0_addr", addr0, 14'd0);
    chk("p0_rdy", a0.HREADYOUT, 1'b1);
    adv;
    ap0(AHB_SEQ, 1'b0, AHB_SIZE_WORD, 32'h4);
    mid;
    chk("p1_data", a0.HRDATA, 32'h1111_1111);
    chk("p1_rdy", a0.HREADYOUT, 1'b1);
    chk("p1_addr", addr0, 14'd1);
    adv;
    ap0(AHB_SEQ, 1'b0, AHB_SIZE_WORD, 32'h8);
    mid;
    chk("p2_data", a0.HRDATA, 32'h2222_2222);
    chk("p2_rdy", a0.HREADYOUT, 1'b1);
    adv;
    idle0;
    mid;
    chk("p3_data", a0.HRDATA, 32'h3333_3333);
    chk("p3_rdy", a0.HREADYOUT, 1'b1);
    adv;
    mid;
    chk("idle_rdata", a0.HRDATA, 32'h0);
    adv;
    ap0(AHB_NONSEQ, 1'b1, AHB_SIZE_WORD, 32'h10);
    adv;
    idle0;
    a0.HWDATA = 32'hCAFE_F00D;
    rst = 1'b1;
    mid;
    chk("rstwr_cs", cs0, 1'b0);
    adv;
    rst = 1'b0;
    mid;
    chk("post_rdy", a0.HREADYOUT, 1'b1);
    chk("post_resp", a0.HRESP, 1'b0);
    chk("post_rdata", a0.HRDATA, 32'h0);
    chk("post_cs", cs0, 1'b0);
    chk("post_we", we0, 1'b0);
    chk("post_be", be0, 4'h0);
    adv;
    ap0(AHB_NONSEQ, 1'b0, AHB_SIZE_WORD, 32'h10);
    adv;
    idle0;
    mid;
    chk("old_data", a0.HRDATA, 32'h1234_BEEF);
    adv;
    a1.HSEL = 1'b1;
    a1.HTRANS = AHB_NONSEQ;
    a1.HADDR = 32'h20;
    mid;
    chk("ws_cs", cs1, 1'b1);
    chk("ws_addr", addr1, 14'd8);
    chk("ws_ap_rdy", a1.HREADYOUT, 1'b1);
    adv;
    a1.HTRANS = AHB_IDLE;
    for (int k = 0; k < 3; k++) begin
      mid;
      chk($sformatf("ws_wait%0d_rdy", k), a1.HREADYOUT, 1'b0);
      chk($sformatf("ws_wait%0d_rdata", k), a1.HRDATA, 32'h0);
      adv;
    end
    mid;
    chk("ws_rdy", a1.HREADYOUT, 1'b1);
    chk("ws_data", a1.HRDATA, 32'h0BAD_CAFE);
    adv;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
